// File: rtl/mem_unit_if.sv
// Request/response and loader signals of mem_unit, grouped for a single port connection.
// The master side is the control unit plus loader; the slave side is the memory.
interface mem_unit_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 9
);
    logic                  enable;
    logic                  read;
    logic                  write;
    logic [ADDR_WIDTH-1:0] address;
    logic [DATA_WIDTH-1:0] data_in;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  busy;
    logic                  done;
    logic                  error;
    logic                  overide;
    logic                  overide_we;
    logic [ADDR_WIDTH-1:0] overide_address;
    logic [DATA_WIDTH-1:0] overide_data_in;

    modport slave (
        input  enable, read, write, address, data_in,
        input  overide, overide_we, overide_address, overide_data_in,
        output data_out, busy, done, error
    );

    modport master (
        output enable, read, write, address, data_in,
        output overide, overide_we, overide_address, overide_data_in,
        input  data_out, busy, done, error
    );
endinterface

// File: rtl/mem_unit.sv
// Multi-cycle word memory with latched requests, busy/done handshake, error reporting
// and a loader port that takes priority over core accesses.
module mem_unit #(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned ADDR_WIDTH  = 9,
    parameter int unsigned DEPTH       = 512,
    parameter int unsigned WAIT_STATES = 1
) (
    input logic       Clock,
    input logic       reset,
    mem_unit_if.slave bus
);
    localparam int unsigned           IdxW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_WIDTH:0]   DepthLim = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [3:0]            WaitInit = 4'(WAIT_STATES);

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    state_e                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  is_write_q, is_write_d;
    logic                  err_q, err_d;
    logic [DATA_WIDTH-1:0] dout_q, dout_d;

    logic            in_range;
    logic [IdxW-1:0] idx;
    logic            core_wr;
    logic            ovr_wr;
    logic [IdxW-1:0] ovr_idx;

    assign in_range = {1'b0, addr_q} < DepthLim;
    assign idx      = addr_q[IdxW-1:0];
    assign ovr_wr   = bus.overide && bus.overide_we && ({1'b0, bus.overide_address} < DepthLim);
    assign ovr_idx  = bus.overide_address[IdxW-1:0];

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        is_write_d = is_write_q;
        err_d      = err_q;
        dout_d     = dout_q;
        core_wr    = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (bus.enable && !bus.overide) begin
                    if (bus.read && bus.write) begin
                        state_d = StDone;
                        err_d   = 1'b1;
                    end else if (bus.read || bus.write) begin
                        state_d    = StBusy;
                        cnt_d      = WaitInit;
                        addr_d     = bus.address;
                        wdata_d    = bus.data_in;
                        is_write_d = bus.write;
                        err_d      = 1'b0;
                    end
                end
            end
            StBusy: begin
                // The loader owns the array while overide is high: freeze and defer the commit.
                if (!bus.overide) begin
                    if (cnt_q == 4'd0) begin
                        state_d = StDone;
                        err_d   = !in_range;
                        if (is_write_q) begin
                            core_wr = in_range;
                        end else begin
                            dout_d = in_range ? mem[idx] : '0;
                        end
                    end else begin
                        cnt_d = cnt_q - 4'd1;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge Clock) begin
        if (!reset) begin
            state_q    <= StIdle;
            cnt_q      <= 4'd0;
            addr_q     <= '0;
            wdata_q    <= '0;
            is_write_q <= 1'b0;
            err_q      <= 1'b0;
            dout_q     <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            is_write_q <= is_write_d;
            err_q      <= err_d;
            dout_q     <= dout_d;
        end
    end

    // Reset aborts a pending core write; loader writes are independent of reset.
    always_ff @(posedge Clock) begin
        if (ovr_wr) begin
            mem[ovr_idx] <= bus.overide_data_in;
        end else if (core_wr && reset) begin
            mem[idx] <= wdata_q;
        end
    end

    assign bus.data_out = dout_q;
    assign bus.busy     = (state_q == StBusy);
    assign bus.done     = (state_q == StDone);
    assign bus.error    = (state_q == StDone) && err_q;
endmodule
